// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM, registers one word for decode.
// Latency address->instruction 1 cycle; holds word/PC while decode stalls. Optional halt via IFETCH_HALT_EN.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] address,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFETCH_HALT_EN
    input  logic        halt,
    output logic        halted,
`endif
    output logic        misalign,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1
`ifdef IFETCH_HALT_EN
        , ST_HALT = 2'd2
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] ipc_nxt;
    logic        mis_nxt;
    logic        fault_nxt;
    logic [31:0] cnt_nxt;
    logic        take;
    logic        slot_free;
    logic        out_of_range;

    assign address      = {2'b00, pc[31:2]};
    assign take         = inst_valid & inst_ready;
    assign slot_free    = ~inst_valid | inst_ready;
    assign out_of_range = ({2'b00, pc[31:2]} >= ROM_DEPTH);

`ifdef IFETCH_HALT_EN
    assign halted = (state == ST_HALT);
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = inst_valid;
        instr_nxt = instruction;
        ipc_nxt   = inst_pc;
        mis_nxt   = misalign;
        fault_nxt = fault;
        // A word handed over counts even when a redirect flushes the slot in the same cycle.
        cnt_nxt   = fetch_count + {31'd0, take};

        if (redirect_valid) begin
            pc_nxt    = {redirect_pc[31:2], 2'b00};
            valid_nxt = 1'b0;
            state_nxt = ST_RUN;
            fault_nxt = 1'b0;
            mis_nxt   = misalign | (|redirect_pc[1:0]);
        end else begin
            case (state)
                ST_RUN: begin
`ifdef IFETCH_HALT_EN
                    if (halt) begin
                        state_nxt = ST_HALT;
                        if (take) valid_nxt = 1'b0;
                    end else
`endif
                    if (slot_free) begin
                        if (out_of_range) begin
                            state_nxt = ST_FAULT;
                            fault_nxt = 1'b1;
                            valid_nxt = 1'b0;
                        end else begin
                            instr_nxt = rom_data;
                            ipc_nxt   = pc;
                            valid_nxt = 1'b1;
                            pc_nxt    = pc + 32'd4;
                        end
                    end
                end
                default: begin
                    // Stopped: no captures, but the held word can still drain.
                    if (take) valid_nxt = 1'b0;
`ifdef IFETCH_HALT_EN
                    if ((state == ST_HALT) && !halt) state_nxt = ST_RUN;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            instruction <= 32'd0;
            inst_pc     <= 32'd0;
            misalign    <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inst_valid  <= valid_nxt;
            instruction <= instr_nxt;
            inst_pc     <= ipc_nxt;
            misalign    <= mis_nxt;
            fault       <= fault_nxt;
            fetch_count <= cnt_nxt;
        end
    end

endmodule
